// File: rtl/fm_nco_ctrl.sv
// rtl/fm_nco_ctrl.sv - FM transmit NCO tuning-word sequencer.
// Handles the ramp up to the carrier, audio-driven deviation while running, and the ramp back to zero.
module fm_nco_ctrl #(
  parameter int FTW_W     = 18,
  parameter int AUDIO_W   = 16,
  parameter int DIV       = 64,
  parameter int RAMP_STEP = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [FTW_W-1:0]   cfg_carrier,
  input  logic [3:0]         cfg_dev_shift,
  input  logic               start,
  input  logic               stop,
  input  logic [AUDIO_W-1:0] audio,
  input  logic               audio_valid,
  output logic               audio_ready,
  output logic [FTW_W-1:0]   ftw,
  output logic               nco_en,
  output logic               busy,
  output logic               underrun
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [FTW_W:0]   STEP_X   = (FTW_W + 1)'(RAMP_STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAMP_UP,
    S_RUN,
    S_RAMP_DOWN
  } state_t;

  state_t             state_q, state_d;
  logic [FTW_W-1:0]   ftw_q, ftw_d;
  logic [FTW_W-1:0]   carrier_q, carrier_d;
  logic [3:0]         dev_shift_q, dev_shift_d;
  logic [AUDIO_W-1:0] held_q, held_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               underrun_q, underrun_d;
  logic               active_q, active_d;

  // Deviation path: two guard bits keep the sum exact so saturation can see both overflow directions.
  logic signed [FTW_W+1:0] held_ext;
  logic signed [FTW_W+1:0] dev;
  logic signed [FTW_W+1:0] sum;
  logic [FTW_W-1:0]        run_ftw;
  logic [FTW_W:0]          up_sum;
  logic                    up_done;
  logic                    down_done;

  assign held_ext = {{(FTW_W + 2 - AUDIO_W){held_q[AUDIO_W-1]}}, held_q};
  assign dev      = held_ext >>> dev_shift_q;
  assign sum      = $signed({2'b00, carrier_q}) + dev;

  always_comb begin
    run_ftw = sum[FTW_W-1:0];
    if (sum[FTW_W+1]) begin
      run_ftw = '0;
    end else if (sum[FTW_W]) begin
      run_ftw = '1;
    end
  end

  assign up_sum    = {1'b0, ftw_q} + STEP_X;
  assign up_done   = (up_sum >= {1'b0, carrier_q});
  assign down_done = ({1'b0, ftw_q} <= STEP_X);

  always_comb begin
    state_d     = state_q;
    ftw_d       = ftw_q;
    carrier_d   = carrier_q;
    dev_shift_d = dev_shift_q;
    held_d      = held_q;
    cnt_d       = cnt_q;
    ready_d     = 1'b0;
    underrun_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        ftw_d = '0;
        if (cfg_we) begin
          carrier_d   = cfg_carrier;
          dev_shift_d = cfg_dev_shift;
        end
        if (start && !stop) begin
          state_d = S_RAMP_UP;
        end
      end

      S_RAMP_UP: begin
        if (stop) begin
          state_d = S_RAMP_DOWN;
        end else if (up_done) begin
          ftw_d   = carrier_q;
          held_d  = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          ftw_d = up_sum[FTW_W-1:0];
        end
      end

      S_RUN: begin
        // ready_q marks the handshake cycle; the transfer lands at the end of it.
        if (ready_q) begin
          if (audio_valid) begin
            held_d = audio;
          end else begin
            underrun_d = 1'b1;
          end
        end
        if (stop) begin
          state_d = S_RAMP_DOWN;
        end else begin
          ftw_d   = run_ftw;
          ready_d = (cnt_q == CNT_LAST);
          cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
      end

      S_RAMP_DOWN: begin
        if (down_done) begin
          ftw_d   = '0;
          state_d = S_IDLE;
        end else begin
          ftw_d = ftw_q - STEP_X[FTW_W-1:0];
        end
      end

      default: begin
        state_d = S_IDLE;
        ftw_d   = '0;
      end
    endcase

    active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ftw_q       <= '0;
      carrier_q   <= '0;
      dev_shift_q <= '0;
      held_q      <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      underrun_q  <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ftw_q       <= ftw_d;
      carrier_q   <= carrier_d;
      dev_shift_q <= dev_shift_d;
      held_q      <= held_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      underrun_q  <= underrun_d;
      active_q    <= active_d;
    end
  end

  assign ftw         = ftw_q;
  assign nco_en      = active_q;
  assign busy        = active_q;
  assign audio_ready = ready_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_fm_nco_ctrl.sv
// tb/tb_fm_nco_ctrl.sv - self-checking bench for fm_nco_ctrl.
// Expected tuning words come from plain integer arithmetic on the carrier, sample and shift.
module tb_fm_nco_ctrl;

  localparam int FTW_W   = 18;
  localparam int AUDIO_W = 16;
  localparam int DIV     = 64;
  localparam int STEP    = 256;
  localparam longint FTW_MAX = (longint'(1) << FTW_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_we;
  logic [FTW_W-1:0]   cfg_carrier;
  logic [3:0]         cfg_dev_shift;
  logic               start;
  logic               stop;
  logic [AUDIO_W-1:0] audio;
  logic               audio_valid;
  logic               audio_ready;
  logic [FTW_W-1:0]   ftw;
  logic               nco_en;
  logic               busy;
  logic               underrun;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int mark   = 0;
  longint held_m = 0;

  fm_nco_ctrl #(
    .FTW_W(FTW_W), .AUDIO_W(AUDIO_W), .DIV(DIV), .RAMP_STEP(STEP)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_carrier(cfg_carrier),
    .cfg_dev_shift(cfg_dev_shift), .start(start), .stop(stop),
    .audio(audio), .audio_valid(audio_valid), .audio_ready(audio_ready),
    .ftw(ftw), .nco_en(nco_en), .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // carrier + floor(sample / 2^shift), clamped to the tuning-word range
  function automatic longint model_ftw(input longint c, input longint s, input int sh);
    longint p, d, v;
    p = longint'(1) << sh;
    if (s >= 0) d = s / p;
    else        d = -((-s + p - 1) / p);
    v = c + d;
    if (v < 0) v = 0;
    if (v > FTW_MAX) v = FTW_MAX;
    return v;
  endfunction

  task automatic ramp_up(input longint c, input int sh);
    longint exp;
    cfg_we = 1'b1; cfg_carrier = c[FTW_W-1:0]; cfg_dev_shift = sh[3:0];
    start = 1'b1;
    step();
    cfg_we = 1'b0; start = 1'b0;
    check("ramp_entry_ftw", ftw, 0);
    check("ramp_entry_en", nco_en, 1);
    check("ramp_entry_busy", busy, 1);
    for (longint k = 1; k < 4096; k++) begin
      exp = (k * STEP < c) ? k * STEP : c;
      step();
      check("ramp_up_ftw", ftw, exp);
      if (exp == c) break;
    end
    held_m = 0;
    mark = cyc;
  endtask

  task automatic do_tick(input longint sample, input bit valid, input longint c, input int sh);
    int n;
    n = 0;
    while (!audio_ready && n < 3 * DIV) begin
      step();
      n++;
    end
    check("tick_seen", audio_ready, 1);
    check("tick_interval", cyc - mark, DIV);
    mark = cyc;
    audio = sample[AUDIO_W-1:0];
    audio_valid = valid;
    step();
    audio_valid = 1'b0;
    check("underrun", underrun, valid ? 0 : 1);
    check("ready_pulse", audio_ready, 0);
    step();
    if (valid) held_m = sample;
    check("run_ftw", ftw, model_ftw(c, held_m, sh));
  endtask

  task automatic ramp_down(input longint from, input bit poke_start);
    longint v;
    bit poked;
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("rd_hold_ftw", ftw, from);
    v = from;
    poked = 1'b0;
    while (v > STEP) begin
      v -= STEP;
      if (poke_start && !poked) start = 1'b1;
      step();
      start = 1'b0;
      poked = 1'b1;
      check("rd_ftw", ftw, v);
      check("rd_busy", busy, 1);
    end
    step();
    check("rd_end_ftw", ftw, 0);
    check("rd_end_en", nco_en, 0);
    check("rd_end_busy", busy, 0);
    step();
    check("idle_after_rd", busy, 0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen_ready, seen_busy, seen_ftw;
    longint c, s;
    int sh;
    rst = 1'b1; cfg_we = 1'b0; cfg_carrier = '0; cfg_dev_shift = '0;
    start = 1'b0; stop = 1'b0; audio = '0; audio_valid = 1'b0;
    repeat (3) step();
    check("rst_ftw", ftw, 0);
    check("rst_en", nco_en, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", audio_ready, 0);
    check("rst_underrun", underrun, 0);
    rst = 1'b0;

    seen_ready = 0; seen_busy = 0; seen_ftw = 0;
    repeat (200) begin
      step();
      seen_ready += int'(audio_ready);
      seen_busy  += int'(busy);
      seen_ftw   += int'(ftw != 0);
    end
    check("idle_ready_count", seen_ready, 0);
    check("idle_busy_count", seen_busy, 0);
    check("idle_ftw_count", seen_ftw, 0);

    // start together with stop stays idle
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    step();
    check("start_stop_idle", busy, 0);

    // ramp, deviation, underrun, config ignored in RUN, stop with start ignored
    ramp_up(1024, 2);
    do_tick(32'sh1000, 1'b1, 1024, 2);
    do_tick(-4096, 1'b1, 1024, 2);
    for (int i = 0; i < 6; i++) begin
      s = longint'($urandom_range(0, 65535)) - 32768;
      if (i == 3) begin
        cfg_we = 1'b1; cfg_carrier = 18'd5; cfg_dev_shift = 4'd0;
      end
      do_tick(s, ($urandom_range(0, 3) != 0) && (i != 1), 1024, 2);
      cfg_we = 1'b0;
    end
    do_tick(0, 1'b1, 1024, 2);
    check("run_ftw_carrier", ftw, 1024);
    ramp_down(1024, 1'b1);

    // positive and negative saturation
    ramp_up(18'h3FF00, 0);
    do_tick(32767, 1'b1, 18'h3FF00, 0);
    check("sat_high", ftw, FTW_MAX);
    ramp_down(FTW_MAX, 1'b0);
    ramp_up(1024, 0);
    do_tick(-32768, 1'b1, 1024, 0);
    check("sat_low", ftw, 0);
    ramp_down(0, 1'b0);

    // stop during ramp-up at 512
    cfg_we = 1'b1; cfg_carrier = 18'd1024; start = 1'b1;
    step();
    cfg_we = 1'b0; start = 1'b0;
    step();
    step();
    check("midramp_ftw", ftw, 512);
    ramp_down(512, 1'b0);

    // random carriers and shifts
    for (int r = 0; r < 3; r++) begin
      c  = longint'($urandom_range(0, 200000));
      sh = int'($urandom_range(0, 15));
      ramp_up(c, sh);
      for (int i = 0; i < 4; i++) begin
        s = longint'($urandom_range(0, 65535)) - 32768;
        do_tick(s, $urandom_range(0, 4) != 0, c, sh);
      end
      ramp_down(model_ftw(c, held_m, sh), 1'b0);
    end

    // zero carrier: one-cycle ramp, then reset while running
    ramp_up(0, 0);
    do_tick(100, 1'b1, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_run_ftw", ftw, 0);
    check("rst_run_en", nco_en, 0);
    check("rst_run_busy", busy, 0);
    check("rst_run_ready", audio_ready, 0);
    check("rst_run_underrun", underrun, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
